vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_fb_arbiter.sv | 92 +++++++++
 tb/tb_vga_fb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: arbitrates full-screen clears and single-dot plots onto one framebuffer write port
module vga_fb_arbiter #(
  parameter int H_DOTS  = 160,
  parameter int V_DOTS  = 120,
  parameter int COLOR_W = 3
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               clr_req,
  input  logic [COLOR_W-1:0] clr_color,
  input  logic               plot_req,
  input  logic [7:0]         plot_x,
  input  logic [6:0]         plot_y,
  input  logic [COLOR_W-1:0] plot_color,
  output logic               plot_ack,
  output logic               busy,
  output logic               done,
  output logic [7:0]         fb_x,
  output logic [6:0]         fb_y,
  output logic [COLOR_W-1:0] fb_color,
  output logic               fb_we
);
  typedef enum logic [1:0] {IDLE, CLEAR, PLOT} state_t;
  state_t             state, state_n;
  logic [7:0]         x_n;
  logic [6:0]         y_n;
  logic [COLOR_W-1:0] c_n;
  logic               we_n, ack_n, done_n, last_x, last_y, in_range;
  assign last_x   = fb_x == 8'(H_DOTS - 1);
  assign last_y   = fb_y == 7'(V_DOTS - 1);
  assign in_range = ({1'b0, plot_x} < 9'(H_DOTS)) && ({1'b0, plot_y} < 8'(V_DOTS));
  // next state and next registered outputs; clear beats plot, requests ignored outside IDLE
  always_comb begin
    state_n = state;
    x_n     = fb_x;
    y_n     = fb_y;
    c_n     = fb_color;
    we_n    = 1'b0;
    ack_n   = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE:
        if (clr_req) begin
          state_n = CLEAR;
          x_n     = '0;
          y_n     = '0;
          c_n     = clr_color;
          we_n    = 1'b1;
        end else if (plot_req) begin
          state_n = PLOT;
          x_n     = plot_x;
          y_n     = plot_y;
          c_n     = plot_color;
          ack_n   = 1'b1;
          we_n    = in_range;
        end
      CLEAR:
        if (last_x && last_y) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          we_n = 1'b1;
          x_n  = last_x ? 8'd0 : fb_x + 8'd1;
          y_n  = last_x ? fb_y + 7'd1 : fb_y;
        end
      PLOT:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state and output registers; reset aborts any clear in progress
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= '0;
      fb_we    <= 1'b0;
      plot_ack <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      fb_x     <= x_n;
      fb_y     <= y_n;
      fb_color <= c_n;
      fb_we    <= we_n;
      plot_ack <= ack_n;
      done     <= done_n;
      busy     <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed table-driven bench for the framebuffer arbiter
module tb_vga_fb_arbiter;
  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       clr_req = 1'b0;
  logic [2:0] clr_color = '0;
  logic       plot_req = 1'b0;
  logic [7:0] plot_x = '0;
  logic [6:0] plot_y = '0;
  logic [2:0] plot_color = '0;
  logic       plot_ack, busy, done, fb_we;
  logic [7:0] fb_x;
  logic [6:0] fb_y;
  logic [2:0] fb_color;
  int n_cmp = 0;
  int n_bad = 0;

  vga_fb_arbiter dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .clr_req(clr_req), .clr_color(clr_color),
    .plot_req(plot_req), .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color),
    .plot_ack(plot_ack), .busy(busy), .done(done), .fb_x(fb_x), .fb_y(fb_y),
    .fb_color(fb_color), .fb_we(fb_we)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       we;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_we"}, fb_we, 0);
    chk({tag, "_ack"}, plot_ack, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_x"}, fb_x, 0);
    chk({tag, "_y"}, fb_y, 0);
    chk({tag, "_color"}, fb_color, 0);
  endtask

  initial begin
    int ex, ey, bad, n;
    tbl[0] = '{x: 8'd37,  y: 7'd85,  c: 3'b010, we: 1'b1};
    tbl[1] = '{x: 8'd0,   y: 7'd0,   c: 3'b111, we: 1'b1};
    tbl[2] = '{x: 8'd159, y: 7'd119, c: 3'b001, we: 1'b1};
    tbl[3] = '{x: 8'd160, y: 7'd10,  c: 3'b011, we: 1'b0};
    tbl[4] = '{x: 8'd5,   y: 7'd120, c: 3'b100, we: 1'b0};
    tbl[5] = '{x: 8'd255, y: 7'd127, c: 3'b110, we: 1'b0};

    step();
    chk_idle_zero("reset");
    step();
    resetn = 1'b1;
    step();
    chk_idle_zero("post_reset_idle");

    clr_req = 1'b1;
    clr_color = 3'b101;
    step();
    clr_req = 1'b0;
    clr_color = 3'b000;
    bad = 0;
    ex = 0;
    ey = 0;
    for (int i = 0; i < 19200; i++) begin
      if (!fb_we || fb_x != ex || fb_y != ey || fb_color != 3'b101 || !busy || done || plot_ack) bad++;
      ex = (ex == 159) ? 0 : ex + 1;
      ey = (ex == 0) ? ey + 1 : ey;
      step();
    end
    chk("clear_raster_bad_cycles", bad, 0);
    chk("clear_end_we", fb_we, 0);
    chk("clear_end_done", done, 1);
    chk("clear_end_busy", busy, 0);
    chk("clear_end_x_hold", fb_x, 159);
    chk("clear_end_y_hold", fb_y, 119);
    step();
    chk("clear_done_one_cycle", done, 0);
    chk("clear_idle_color_hold", fb_color, 3'b101);

    foreach (tbl[i]) begin
      plot_x = tbl[i].x;
      plot_y = tbl[i].y;
      plot_color = tbl[i].c;
      plot_req = 1'b1;
      step();
      plot_req = 1'b0;
      chk($sformatf("plot%0d_ack", i), plot_ack, 1);
      chk($sformatf("plot%0d_we", i), fb_we, tbl[i].we);
      chk($sformatf("plot%0d_x", i), fb_x, tbl[i].x);
      chk($sformatf("plot%0d_y", i), fb_y, tbl[i].y);
      chk($sformatf("plot%0d_color", i), fb_color, tbl[i].c);
      chk($sformatf("plot%0d_busy", i), busy, 1);
      step();
      chk($sformatf("plot%0d_idle_ack", i), plot_ack, 0);
      chk($sformatf("plot%0d_idle_we", i), fb_we, 0);
      chk($sformatf("plot%0d_idle_busy", i), busy, 0);
      chk($sformatf("plot%0d_idle_x_hold", i), fb_x, tbl[i].x);
      step();
      chk($sformatf("plot%0d_no_more_we", i), fb_we, 0);
    end

    clr_req = 1'b1;
    clr_color = 3'b110;
    plot_req = 1'b1;
    plot_x = 8'd12;
    plot_y = 7'd34;
    plot_color = 3'b011;
    step();
    clr_req = 1'b0;
    chk("both_clear_wins_ack", plot_ack, 0);
    chk("both_clear_wins_x", fb_x, 0);
    chk("both_clear_wins_color", fb_color, 3'b110);
    n = 0;
    bad = 0;
    while (!done && n < 20000) begin
      if (plot_ack || !fb_we) bad++;
      step();
      n++;
    end
    chk("both_clear_cycles", n, 19200);
    chk("both_no_ack_during_clear", bad, 0);
    chk("both_done_cycle_ack", plot_ack, 0);
    step();
    plot_req = 1'b0;
    chk("both_plot_ack", plot_ack, 1);
    chk("both_plot_we", fb_we, 1);
    chk("both_plot_x", fb_x, 12);
    chk("both_plot_y", fb_y, 34);
    chk("both_plot_color", fb_color, 3'b011);
    step();

    clr_req = 1'b1;
    clr_color = 3'b111;
    step();
    clr_req = 1'b0;
    n = 0;
    while (!(fb_x == 80 && fb_y == 60) && n < 20000) begin
      step();
      n++;
    end
    chk("abort_reach_cycles", n, 60 * 160 + 80);
    chk("abort_pre_we", fb_we, 1);
    resetn = 1'b0;
    #1;
    chk_idle_zero("abort_reset");
    #2;
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (fb_we || done || busy || plot_ack) bad++;
    end
    chk("abort_no_resume", bad, 0);

    plot_x = 8'd7;
    plot_y = 7'd9;
    plot_color = 3'b101;
    plot_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("held%0d_ack", i), plot_ack, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("held%0d_we", i), fb_we, (i % 2 == 0) ? 1 : 0);
    end
    plot_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
